// File: rtl/xgmii_probe_rx.sv
// Receive-side analyser for XGMII IPv4/UDP test frames: latency, source IP, per-second packet/byte counts.
// Optional macro RX_LATENCY_MAX_EN adds rx_latency_max (largest latency seen in the last second).
module xgmii_probe_rx #(
    parameter logic [31:0] MAGIC_CODE = 32'h4E55_4D41,
    parameter logic [15:0] MAX_WORDS  = 16'd192
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
`ifdef RX_LATENCY_MAX_EN
    output logic [23:0] rx_latency_max,
`endif
    output logic [31:0] rx_ipv4_ip
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] word_idx_r;
    logic [15:0] word_idx_nxt_s;

    logic [7:0]  lane_s [8];
    logic        start_s;
    logic        idle_s;
    logic [7:0]  term_hit_s;
    logic [7:0]  fe_hit_s;
    logic [7:0]  pre_mask_s;
    logic        term_found_s;
    logic [2:0]  term_lane_s;
    logic        err_s;
    logic        hdr_ok_s;
    logic [15:0] len_s;
    logic        commit_s;
    logic [31:0] diff_s;
    logic [23:0] lat_sat_s;

    logic [31:0] src_ip_r;
    logic [31:0] ts_r;
    logic        commit_r;
    logic [15:0] commit_len_r;
    logic [23:0] commit_lat_r;
    logic [31:0] pps_acc_r;
    logic [31:0] byte_acc_r;
`ifdef RX_LATENCY_MAX_EN
    logic [23:0] lat_max_acc_r;
`endif

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Lane split and control-character classification of the current word
    always_comb begin
        term_found_s = 1'b0;
        term_lane_s  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            lane_s[i]     = xgmii_rxd[8*i +: 8];
            term_hit_s[i] = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFD);
            fe_hit_s[i]   = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFE);
        end
        for (int i = 7; i >= 0; i--) begin
            term_lane_s = term_hit_s[i] ? 3'(i) : term_lane_s;
        end
        term_found_s = |term_hit_s;
        // Lanes below the lowest terminate (all lanes when there is none) must carry data
        pre_mask_s   = (term_hit_s & (~term_hit_s + 8'd1)) - 8'd1;
        err_s        = (|fe_hit_s) || (|(xgmii_rxc & pre_mask_s));
        start_s      = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);
        idle_s       = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'h07);
        len_s        = {word_idx_r[12:0] - 13'd1, term_lane_s};
        diff_s       = global_counter - ts_r;
        lat_sat_s    = (diff_s[31:24] == 8'd0) ? diff_s[23:0] : 24'hFF_FFFF;
    end

    // Header field checks for the word currently at word_idx_r
    always_comb begin
        hdr_ok_s = 1'b1;
        case (word_idx_r)
            16'd2:   hdr_ok_s = (lane_s[4] == 8'h08) && (lane_s[5] == 8'h00) && (lane_s[6] == 8'h45);
            16'd3:   hdr_ok_s = (lane_s[7] == 8'h11);
            16'd6:   hdr_ok_s = ({lane_s[2], lane_s[3], lane_s[4], lane_s[5]} == MAGIC_CODE);
            default: hdr_ok_s = 1'b1;
        endcase
    end

    // Next-state logic; a start word restarts parsing from any state
    always_comb begin
        state_nxt_s    = state_r;
        word_idx_nxt_s = word_idx_r;
        commit_s       = 1'b0;
        if (start_s) begin
            state_nxt_s    = ST_HDR;
            word_idx_nxt_s = 16'd1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_HDR: begin
                    word_idx_nxt_s = word_idx_r + 16'd1;
                    if (err_s) begin
                        state_nxt_s = ST_DROP;
                    end else if (term_found_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!hdr_ok_s) begin
                        state_nxt_s = ST_DROP;
                    end else if (word_idx_r == 16'd7) begin
                        state_nxt_s = ST_BODY;
                    end else begin
                        state_nxt_s = ST_HDR;
                    end
                end
                ST_BODY: begin
                    word_idx_nxt_s = word_idx_r + 16'd1;
                    if (word_idx_r > MAX_WORDS) begin
                        state_nxt_s = ST_DROP;
                    end else if (err_s) begin
                        state_nxt_s = ST_DROP;
                    end else if (term_found_s) begin
                        state_nxt_s = ST_IDLE;
                        commit_s    = (len_s >= 16'd64);
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end
                ST_DROP: begin
                    if (term_found_s || idle_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and word index registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            word_idx_r <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            word_idx_r <= word_idx_nxt_s;
        end
    end

    // Header field capture and the one-cycle commit pipeline stage
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            src_ip_r     <= 32'd0;
            ts_r         <= 32'd0;
            commit_r     <= 1'b0;
            commit_len_r <= 16'd0;
            commit_lat_r <= 24'd0;
        end else begin
            if ((state_r == ST_HDR) && !start_s && (word_idx_r == 16'd4)) begin
                src_ip_r <= {lane_s[2], lane_s[3], lane_s[4], lane_s[5]};
            end
            if ((state_r == ST_HDR) && !start_s && (word_idx_r == 16'd6)) begin
                ts_r[31:16] <= {lane_s[6], lane_s[7]};
            end
            if ((state_r == ST_HDR) && !start_s && (word_idx_r == 16'd7)) begin
                ts_r[15:0] <= {lane_s[0], lane_s[1]};
            end
            commit_r     <= commit_s;
            commit_len_r <= len_s;
            commit_lat_r <= lat_sat_s;
        end
    end

    // Per-second accumulation; a frame committing on the pulse seeds the next window
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_pps        <= 32'd0;
            rx_throughput <= 32'd0;
            rx_latency    <= 24'd0;
            rx_ipv4_ip    <= 32'd0;
            pps_acc_r     <= 32'd0;
            byte_acc_r    <= 32'd0;
        end else begin
            if (commit_r) begin
                rx_latency <= commit_lat_r;
                rx_ipv4_ip <= src_ip_r;
            end
            if (sec_oneshot) begin
                rx_pps        <= pps_acc_r;
                rx_throughput <= byte_acc_r;
                pps_acc_r     <= commit_r ? 32'd1 : 32'd0;
                byte_acc_r    <= commit_r ? {16'd0, commit_len_r} : 32'd0;
            end else if (commit_r) begin
                pps_acc_r  <= sat_add32(pps_acc_r, 32'd1);
                byte_acc_r <= sat_add32(byte_acc_r, {16'd0, commit_len_r});
            end
        end
    end

`ifdef RX_LATENCY_MAX_EN
    // Running maximum latency, published once per second
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_latency_max <= 24'd0;
            lat_max_acc_r  <= 24'd0;
        end else begin
            if (sec_oneshot) begin
                rx_latency_max <= lat_max_acc_r;
                lat_max_acc_r  <= commit_r ? commit_lat_r : 24'd0;
            end else if (commit_r && (commit_lat_r > lat_max_acc_r)) begin
                lat_max_acc_r <= commit_lat_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xgmii_probe_rx.sv
// Scoreboard bench for xgmii_probe_rx: frames are built as byte arrays, judged against the
// frame rules, and the expected per-second snapshot is queued for a monitor to compare.
module tb_xgmii_probe_rx;

    localparam logic [31:0] MAGIC   = 32'h4E55_4D41;
    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sec_oneshot = 1'b0;
    logic [31:0] global_counter = 32'd0;
    logic [63:0] xgmii_rxd = 64'h0707_0707_0707_0707;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic [31:0] rx_pps;
    logic [31:0] rx_throughput;
    logic [23:0] rx_latency;
    logic [31:0] rx_ipv4_ip;
`ifdef RX_LATENCY_MAX_EN
    logic [23:0] rx_latency_max;
`endif

    xgmii_probe_rx dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
`ifdef RX_LATENCY_MAX_EN
        .rx_latency_max (rx_latency_max),
`endif
        .rx_ipv4_ip     (rx_ipv4_ip)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] pps;
        logic [31:0] thr;
        logic [23:0] lat;
        logic [31:0] ip;
        logic [23:0] lmax;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   os_in  = -1;

    // reference model: window accumulators and the frame awaiting commit
    longint      m_pps = 0, m_bytes = 0;
    logic [23:0] m_lat = 24'd0, m_lmax = 24'd0;
    logic [31:0] m_ip = 32'd0;
    logic        pend_v = 1'b0, stage_v = 1'b0;
    int          pend_len = 0, stage_len = 0;
    logic [23:0] pend_lat = 24'd0, stage_lat = 24'd0;
    logic [31:0] pend_ip = 32'd0, stage_ip = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock of stimulus; the model applies the rules for what this edge does
    task automatic cycle(input logic [63:0] d, input logic [7:0] c, input logic [31:0] gc, input logic rst);
        logic os;
        exp_t e;
        os = (os_in == 0);
        if (os_in >= 0) os_in--;
        xgmii_rxd = d; xgmii_rxc = c; global_counter = gc; sec_oneshot = os; sys_rst = rst;
        if (rst) begin
            m_pps = 0; m_bytes = 0; m_lat = 24'd0; m_lmax = 24'd0; m_ip = 32'd0;
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                m_lat = pend_lat;
                m_ip  = pend_ip;
            end
            if (os) begin
                e.pps = m_pps[31:0]; e.thr = m_bytes[31:0]; e.lat = m_lat; e.ip = m_ip; e.lmax = m_lmax;
                exp_q.push_back(e);
                m_pps   = pend_v ? 1 : 0;
                m_bytes = pend_v ? pend_len : 0;
                m_lmax  = pend_v ? pend_lat : 24'd0;
            end else if (pend_v) begin
                m_pps   = (m_pps + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_pps + 1;
                m_bytes = (m_bytes + pend_len > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bytes + pend_len;
                if (pend_lat > m_lmax) m_lmax = pend_lat;
            end
            pend_v = stage_v; pend_len = stage_len; pend_lat = stage_lat; pend_ip = stage_ip;
        end
        stage_v = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(IDLE_D, 8'hFF, $urandom, 1'b0);
    endtask

    task automatic pulse_os();
        os_in = 0;
        cycle(IDLE_D, 8'hFF, $urandom, 1'b0);
    endtask

    // mod: 0 good, 1 magic, 2 ethertype, 3 FE at mod_word, 4 abort before mod_word, 5 proto, 6 IHL byte
    task automatic send_frame(input int len, input logic [31:0] ip, input logic [31:0] ts,
                              input logic [31:0] gc_term, input int mod, input int mod_word, input int gap);
        logic [7:0]  fb [$];
        logic [63:0] d;
        logic [7:0]  c;
        logic [31:0] diff;
        logic        valid;
        int          w, nb, n;
        nb = (len < 50) ? 50 : len;
        for (int k = 0; k < nb; k++) fb.push_back(8'($urandom));
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
        for (int k = 0; k < 4; k++) begin
            fb[26+k] = ip[31-8*k -: 8];
            fb[42+k] = MAGIC[31-8*k -: 8];
            fb[46+k] = ts[31-8*k -: 8];
        end
        if (mod == 1) fb[45] = fb[45] ^ 8'h01;
        if (mod == 2) begin fb[12] = 8'h86; fb[13] = 8'hDD; end
        if (mod == 5) fb[23] = 8'h06;
        if (mod == 6) fb[14] = 8'h46;
        w = 1 + len / 8;
        valid = (fb[12] == 8'h08) && (fb[13] == 8'h00) && (fb[14] == 8'h45) && (fb[23] == 8'h11)
             && ({fb[42], fb[43], fb[44], fb[45]} == MAGIC)
             && (len >= 64) && (w <= 192) && (mod != 3) && (mod != 4);
        diff = gc_term - ts;
        cycle(START_D, 8'h01, $urandom, 1'b0);
        for (int wi = 1; wi <= w; wi++) begin
            if (mod == 4 && wi == mod_word) return;
            for (int ln = 0; ln < 8; ln++) begin
                n = (wi - 1) * 8 + ln;
                if (n < len) begin d[8*ln +: 8] = fb[n]; c[ln] = 1'b0; end
                else if (n == len) begin d[8*ln +: 8] = 8'hFD; c[ln] = 1'b1; end
                else begin d[8*ln +: 8] = 8'h07; c[ln] = 1'b1; end
            end
            if (mod == 3 && wi == mod_word) begin d[31:24] = 8'hFE; c[3] = 1'b1; end
            if (wi == w) begin
                stage_v   = valid;
                stage_len = len;
                stage_lat = (diff < 32'h0100_0000) ? diff[23:0] : 24'hFF_FFFF;
                stage_ip  = ip;
                cycle(d, c, gc_term, 1'b0);
            end else begin
                cycle(d, c, $urandom, 1'b0);
            end
        end
        idle(gap);
    endtask

    // Monitor: each published snapshot is compared against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            if (sec_oneshot === 1'b1 && sys_rst === 1'b0) begin
                @(negedge sys_clk);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got publish with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pps", rx_pps, e.pps);
                    check("sb_throughput", rx_throughput, e.thr);
                    check("sb_latency", {8'd0, rx_latency}, {8'd0, e.lat});
                    check("sb_ip", rx_ipv4_ip, e.ip);
`ifdef RX_LATENCY_MAX_EN
                    check("sb_latency_max", {8'd0, rx_latency_max}, {8'd0, e.lmax});
`endif
                end
            end
        end
    end

    initial begin
        int len, mod, mw;
        logic [31:0] ts;
        #1;
        cycle(IDLE_D, 8'hFF, 32'd0, 1'b1);
        cycle(IDLE_D, 8'hFF, 32'd0, 1'b1);
        check("rst_pps", rx_pps, 32'd0);
        check("rst_thr", rx_throughput, 32'd0);
        check("rst_lat", {8'd0, rx_latency}, 32'd0);
        check("rst_ip", rx_ipv4_ip, 32'd0);
        idle(3);

        // single 64-byte frame
        send_frame(64, 32'h0A00_1401, 32'h0000_1000, 32'h0000_1234, 0, 0, 2);
        pulse_os();
        check("t1_lat", {8'd0, rx_latency}, 32'h0000_0234);
        check("t1_ip", rx_ipv4_ip, 32'h0A00_1401);
        check("t1_pps", rx_pps, 32'd1);
        check("t1_thr", rx_throughput, 32'd64);

        // 1000 back-to-back frames, then one committing on the pulse
        for (int k = 0; k < 1000; k++) begin
            ts = $urandom;
            send_frame(64, $urandom, ts, ts + $urandom_range(0, 32'h0200_0000), 0, 0, 0);
        end
        os_in = 10;
        send_frame(64, 32'hC0A8_0001, 32'd100, 32'd150, 0, 0, 2);
        check("t2_pps", rx_pps, 32'd1000);
        check("t2_thr", rx_throughput, 32'd64000);
        pulse_os();
        check("t2_next_pps", rx_pps, 32'd1);
        check("t2_next_thr", rx_throughput, 32'd64);

        // dropped frames
        send_frame(64, 32'h0101_0101, 32'd0, 32'd9, 1, 0, 1);
        send_frame(64, 32'h0202_0202, 32'd0, 32'd9, 2, 0, 1);
        send_frame(64, 32'h0303_0303, 32'd0, 32'd9, 3, 5, 1);
        pulse_os();
        check("t3_pps", rx_pps, 32'd0);
        check("t3_lat", {8'd0, rx_latency}, 32'd50);

        // saturation and wrap of latency
        send_frame(64, 32'h0404_0404, 32'h0100_0000, 32'h0300_0000, 0, 0, 1);
        pulse_os();
        check("t4_sat", {8'd0, rx_latency}, 32'h00FF_FFFF);
        send_frame(64, 32'h0505_0505, 32'hFFFF_FFF0, 32'h0000_0010, 0, 0, 1);
        pulse_os();
        check("t4_wrap", {8'd0, rx_latency}, 32'h0000_0020);

        // abort by start word, oversize, 128-byte frame
        send_frame(64, 32'h0606_0606, 32'd0, 32'd1, 4, 4, 0);
        send_frame(64, 32'h0707_0707, 32'd0, 32'd1, 0, 0, 1);
        pulse_os();
        check("t5_abort_pps", rx_pps, 32'd1);
        check("t5_abort_ip", rx_ipv4_ip, 32'h0707_0707);
        send_frame(1600, 32'h0808_0808, 32'd0, 32'd1, 0, 0, 1);
        pulse_os();
        check("t5_oversize_pps", rx_pps, 32'd0);
        send_frame(128, 32'h0909_0909, 32'd0, 32'd1, 0, 0, 1);
        pulse_os();
        check("t5_len128", rx_throughput, 32'd128);

        // reset mid-frame, recovery, latency maximum
        send_frame(64, 32'h0A0A_0A0A, 32'd0, 32'd1, 0, 0, 0);
        send_frame(64, 32'h0B0B_0B0B, 32'd0, 32'd1, 4, 5, 0);
        cycle(IDLE_D, 8'hFF, 32'd0, 1'b1);
        check("t6_rst_pps", rx_pps, 32'd0);
        check("t6_rst_lat", {8'd0, rx_latency}, 32'd0);
        check("t6_rst_ip", rx_ipv4_ip, 32'd0);
        send_frame(64, 32'h0C0C_0C0C, 32'd1000, 32'd1005, 0, 0, 1);
        send_frame(64, 32'h0C0C_0C0D, 32'd1000, 32'd1300, 0, 0, 0);
        send_frame(64, 32'h0C0C_0C0E, 32'd1000, 32'd1020, 0, 0, 1);
        pulse_os();
        check("t6_pps", rx_pps, 32'd3);
        check("t6_lat", {8'd0, rx_latency}, 32'd20);
`ifdef RX_LATENCY_MAX_EN
        check("t6_lat_max", {8'd0, rx_latency_max}, 32'd300);
`endif

        // randomized mix with occasional per-second pulses at arbitrary cycles
        for (int k = 0; k < 150; k++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 63) : $urandom_range(64, 300);
            mod = $urandom_range(0, 12);
            if (mod > 6) mod = 0;
            mw = $urandom_range(1, len / 8);
            ts = $urandom;
            if (os_in < 0 && $urandom_range(0, 5) == 0) os_in = $urandom_range(0, 30);
            send_frame(len, $urandom, ts,
                       ($urandom_range(0, 3) == 0) ? $urandom : ts + $urandom_range(0, 32'h0200_0000),
                       mod, mw, (mod == 4) ? 0 : $urandom_range(0, 2));
        end
        idle(40);
        pulse_os();
        idle(3);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
